// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Also provides a word-alignment helper used when loading the PC.
package ifetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2
  } state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_timeout.sv
// Wait-cycle counter for an outstanding fetch request.
// tc_o is high once LIMIT-1 cycles without ack have already elapsed.
module ifetch_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tc_o = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: owns the PC, reads instruction memory over
// req/ack, and strobes IRWr for one cycle. Optional timeout: IFETCH_TIMEOUT_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_go,
  input  logic               pc_ld,
  input  logic [31:0]        pc_ld_val,
  output logic [31:0]        im_addr,
  output logic               im_req,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] im_dout,
  output logic               IRWr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               busy,
  output logic               fetch_err
);

  state_e              state_q;
  logic [31:0]         pc_q;
  logic [31:0]         im_addr_q;
  logic                im_req_q;
  logic [INSTR_W-1:0]  im_dout_q;
  logic                irwr_q;
  logic                fetch_err_q;
  logic [31:0]         pc_inc_d;
  logic                timeout_hit;

  if (TIMEOUT_CYCLES < 2 || RESET_PC[1:0] != 2'b00) begin : g_bad_cfg
    $error("ifetch_unit: TIMEOUT_CYCLES must be >= 2 and RESET_PC word aligned");
  end

`ifdef IFETCH_TIMEOUT_EN
  logic timeout_tc;

  // Counter is held clear outside REQ, so it restarts on every entry.
  ifetch_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != REQ),
    .inc_i ((state_q == REQ) && !im_ack),
    .tc_o  (timeout_tc)
  );

  assign timeout_hit = (state_q == REQ) && !im_ack && timeout_tc;
`else
  assign timeout_hit = 1'b0;
`endif

  assign pc_inc_d = pc_q + PC_INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      im_addr_q   <= RESET_PC;
      im_req_q    <= 1'b0;
      im_dout_q   <= '0;
      irwr_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      irwr_q      <= 1'b0;
      fetch_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A redirect takes priority over a fetch request in the same cycle.
          if (pc_ld) begin
            pc_q <= word_align(pc_ld_val);
          end else if (fetch_go) begin
            state_q   <= REQ;
            im_req_q  <= 1'b1;
            im_addr_q <= pc_q;
          end
        end
        REQ: begin
          if (im_ack) begin
            im_dout_q <= im_rdata;
            pc_q      <= pc_inc_d;
            im_req_q  <= 1'b0;
            irwr_q    <= 1'b1;
            state_q   <= DELIVER;
          end else if (timeout_hit) begin
            im_req_q    <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        DELIVER: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign im_addr   = im_addr_q;
  assign im_req    = im_req_q;
  assign im_dout   = im_dout_q;
  assign IRWr      = irwr_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_inc_d;
  assign busy      = (state_q != IDLE);
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, corner-case
// sequences, and randomized fetch/redirect traffic against a PC model.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          TO     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_go = 1'b0;
  logic        pc_ld = 1'b0;
  logic [31:0] pc_ld_val = '0;
  logic [31:0] im_addr;
  logic        im_req;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic [31:0] im_dout;
  logic        IRWr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        fetch_err;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] model_pc;
  logic [31:0] model_dout;

  ifetch_unit #(
    .RESET_PC       (RST_PC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_go  (fetch_go),
    .pc_ld     (pc_ld),
    .pc_ld_val (pc_ld_val),
    .im_addr   (im_addr),
    .im_req    (im_req),
    .im_ack    (im_ack),
    .im_rdata  (im_rdata),
    .im_dout   (im_dout),
    .IRWr      (IRWr),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ld;
    bit          go_too;
    bit          noise;
    int          delay;
    logic [31:0] val;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch with ack on REQ cycle 'delay' (1 = same cycle im_req rises).
  task automatic do_fetch(input int delay, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                          input bit noise);
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    for (int c = 1; c <= delay; c++) begin
      chk1("req_high", im_req, 1'b1);
      chk("req_addr", im_addr, exp_addr);
      chk1("irwr_in_req", IRWr, 1'b0);
      chk1("busy_in_req", busy, 1'b1);
      chk1("ferr_in_req", fetch_err, 1'b0);
      if (noise) begin
        fetch_go  = 1'($urandom_range(0, 1));
        pc_ld     = 1'($urandom_range(0, 1));
        pc_ld_val = $urandom;
      end
      if (c == delay) begin
        im_ack   = 1'b1;
        im_rdata = rdata;
      end
      tick();
      im_ack   = 1'b0;
      im_rdata = $urandom;
    end
    fetch_go = 1'b0;
    pc_ld    = 1'b0;
    chk1("irwr_deliver", IRWr, 1'b1);
    chk("dout_deliver", im_dout, rdata);
    chk("pc_after_ack", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk1("req_dropped", im_req, 1'b0);
    tick();
    chk1("irwr_single", IRWr, 1'b0);
    chk1("idle_after", busy, 1'b0);
    chk("dout_retained", im_dout, rdata);
    model_dout = rdata;
    $display("fetch addr=%h delay=%0d word=%h pc=%h", exp_addr, delay, rdata, pc);
  endtask

  // PC redirect in IDLE; a stray ack and optional fetch_go must have no effect.
  task automatic do_load(input logic [31:0] val, input bit go_too);
    logic [31:0] exp_pc;
    exp_pc    = val & 32'hFFFF_FFFC;
    pc_ld     = 1'b1;
    pc_ld_val = val;
    fetch_go  = go_too;
    im_ack    = 1'b1;
    im_rdata  = $urandom;
    tick();
    pc_ld    = 1'b0;
    fetch_go = 1'b0;
    im_ack   = 1'b0;
    chk("pc_loaded", pc, exp_pc);
    chk1("no_req_on_load", im_req, 1'b0);
    chk1("no_irwr_on_load", IRWr, 1'b0);
    chk("dout_kept_on_load", im_dout, model_dout);
    tick();
    chk1("load_beats_go", busy, 1'b0);
    model_pc = exp_pc;
    $display("load val=%h go=%0d pc=%h", val, go_too, pc);
  endtask

  initial begin
    vt[0] = '{0, 0, 0, 3, 32'h2008_0005, 32'h0000_3000, 32'h0000_3004};
    vt[1] = '{0, 0, 0, 1, 32'h1111_1111, 32'h0000_3004, 32'h0000_3008};
    vt[2] = '{0, 0, 0, 1, 32'h2222_2222, 32'h0000_3008, 32'h0000_300C};
    vt[3] = '{1, 1, 0, 0, 32'h0040_0013, 32'h0000_0000, 32'h0040_0010};
    vt[4] = '{0, 0, 0, 2, 32'h3333_3333, 32'h0040_0010, 32'h0040_0014};
    vt[5] = '{1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFC};
    vt[6] = '{0, 0, 1, 4, 32'h4444_4444, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[7] = '{0, 0, 1, 1, 32'h5555_5555, 32'h0000_0000, 32'h0000_0004};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", im_addr, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
    chk("rst_dout", im_dout, 32'h0);
    chk1("rst_req", im_req, 1'b0);
    chk1("rst_irwr", IRWr, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ferr", fetch_err, 1'b0);
    rst = 1'b0;
    model_pc   = RST_PC;
    model_dout = '0;
    tick();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      if (vt[i].is_ld) begin
        do_load(vt[i].val, vt[i].go_too);
        chk("vec_pc", pc, vt[i].exp_pc);
      end else begin
        do_fetch(vt[i].delay, vt[i].val, vt[i].exp_addr, vt[i].exp_pc, vt[i].noise);
        model_pc = vt[i].exp_pc;
      end
    end

    // Reset in the middle of a request, then a late ack
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    chk1("pre_rst_req", im_req, 1'b1);
    rst = 1'b1;
    #1;
    chk1("async_rst_req", im_req, 1'b0);
    chk("async_rst_pc", pc, RST_PC);
    tick();
    rst      = 1'b0;
    im_ack   = 1'b1;
    im_rdata = 32'hDEAD_BEEF;
    tick();
    im_ack = 1'b0;
    chk1("late_ack_irwr", IRWr, 1'b0);
    chk1("late_ack_busy", busy, 1'b0);
    chk("late_ack_dout", im_dout, 32'h0);
    chk("late_ack_pc", pc, RST_PC);
    tick();
    chk1("late_ack_irwr2", IRWr, 1'b0);
    model_pc   = RST_PC;
    model_dout = '0;
    $display("reset mid-REQ pc=%h dout=%h", pc, im_dout);

`ifdef IFETCH_TIMEOUT_EN
    // No ack: request abandoned after TO cycles with a single error pulse
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      chk1("to_req_held", im_req, 1'b1);
      chk1("to_no_err_yet", fetch_err, 1'b0);
      tick();
    end
    chk1("to_req_drop", im_req, 1'b0);
    chk1("to_err_pulse", fetch_err, 1'b1);
    chk1("to_no_irwr", IRWr, 1'b0);
    chk1("to_idle", busy, 1'b0);
    chk("to_pc_kept", pc, model_pc);
    chk("to_dout_kept", im_dout, model_dout);
    tick();
    chk1("to_err_single", fetch_err, 1'b0);
    $display("timeout pc=%h", pc);
    // Ack on the limit cycle counts as success
    do_fetch(TO, 32'h6666_6666, model_pc, model_pc + 32'd4, 0);
    model_pc = model_pc + 32'd4;
`endif

    // Randomized traffic against the PC model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [31:0] v;
        v = $urandom;
        do_load(v, 1'($urandom_range(0, 1)));
      end else begin
        logic [31:0] rd;
        int d;
        rd = $urandom;
        d  = $urandom_range(1, TO);
        do_fetch(d, rd, model_pc, model_pc + 32'd4, 1);
        model_pc = model_pc + 32'd4;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch front-end for the multi-cycle core. It owns the PC and issues word reads to instruction memory over a req/ack handshake. It registers the returned word and delivers it to the instruction register as a data word plus a one-cycle write strobe (im_dout, IRWr). The control FSM starts each fetch and can redirect the PC for branches and jumps.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset; bits [1:0] must be 0.
TIMEOUT_CYCLES, 16, cycles an outstanding request may wait for ack (used only with IFETCH_TIMEOUT_EN); minimum 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
fetch_go  in  1  control FSM requests one instruction fetch.
pc_ld  in  1  load PC from pc_ld_val (branch/jump redirect).
pc_ld_val  in  32  new PC; bits [1:0] ignored (forced 0).
im_addr  out  32  instruction memory word address (byte address, aligned).
im_req  out  1  read request, held until ack.
im_ack  in  1  memory returns data this cycle.
im_rdata  in  32  memory read data, valid when im_ack=1.
im_dout  out  32  registered instruction word toward the instruction register.
IRWr  out  1  one-cycle strobe: instruction register captures im_dout.
pc  out  32  current PC.
pc_plus4  out  32  pc+4, combinational, for link/branch arithmetic.
busy  out  1  fetch in progress (state != IDLE).
fetch_err  out  1  one-cycle timeout pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, im_req=0, im_addr=RESET_PC, im_dout=0, IRWr=0, fetch_err=0, timeout counter=0. Reset mid-fetch abandons the request immediately; a late im_ack after reset is ignored.
- States: IDLE, REQ, DELIVER.
- IDLE, pc_ld=1: pc <= {pc_ld_val[31:2],2'b00}. If pc_ld and fetch_go are asserted together, the load wins and fetch_go is ignored that cycle.
- IDLE, fetch_go=1 and pc_ld=0: go to REQ; im_req=1 and im_addr=pc from the next cycle (registered).
- REQ: im_req and im_addr are held stable until im_ack=1.
- REQ, on im_ack=1: im_dout <= im_rdata; pc <= pc+4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0); go to DELIVER.
- REQ: im_req deasserts in the cycle after the ack edge.
- DELIVER: IRWr=1 for exactly this cycle, and im_dout holds the word. Next state is IDLE.
- im_dout retains its value until the next ack.
- fetch_go and pc_ld are ignored while busy=1.
- An ack arriving in the same cycle the request is first raised is legal. Minimum latency is fetch_go at cycle 0, im_req at cycle 1, ack at cycle 1, IRWr at cycle 2.
- im_ack outside REQ is ignored.
- IRWr is never asserted outside DELIVER.

Optional Feature:
IFETCH_TIMEOUT_EN
- Defined: a counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES:
  - im_req drops;
  - fetch_err pulses for 1 cycle;
  - pc is unchanged, im_dout is unchanged, no IRWr;
  - the state returns to IDLE.
  An ack in the same cycle the limit is reached counts as success, not timeout.
- Undefined: REQ waits indefinitely; fetch_err is constant 0; the counter is not synthesized.

Decomposition:
- Package ifetch_pkg: state enum (IDLE/REQ/DELIVER), INSTR_W=32, PC_INC=32'd4, default RESET_PC constant.
- One natural sub-module, ifetch_timeout: load/clear/increment counter with a terminal-count output, instantiated only under IFETCH_TIMEOUT_EN.

Test Plan:
- Reset, then fetch_go for 1 cycle, im_ack=1 with im_rdata=32'h2008_0005 on the 3rd REQ cycle: im_addr=0x3000 throughout REQ; IRWr high exactly 1 cycle after the ack; im_dout=32'h2008_0005; pc=0x3004.
- Ack in the first REQ cycle: IRWr appears 2 cycles after fetch_go; back-to-back fetch_go pulses give consecutive addresses 0x3000, 0x3004, 0x3008.
- pc_ld=1 with pc_ld_val=0x0040_0013 in IDLE: pc=0x0040_0010; a simultaneous fetch_go is ignored (no im_req); the next fetch uses im_addr=0x0040_0010.
- pc loaded to 0xFFFF_FFFC, then fetch with ack: pc=0x0000_0000. fetch_go and pc_ld pulsed during REQ: no effect on address or pc.
- rst asserted mid-REQ, then im_ack pulsed after release: pc=RESET_PC, im_req=0, no IRWr, im_dout=0.
- IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack: im_req drops after 4 REQ cycles; fetch_err pulses once; pc unchanged; no IRWr. Repeat with ack on the 4th cycle: normal delivery, fetch_err=0.
